csa_booth16_seq_mult: RTL and testbench

- Sequential radix-16 Booth multiplier for signed two's-complement operands.
- Retires one Booth digit per cycle into a 2*WIDTH carry-save accumulator (3:2 compressor row).
- Ends with a single carry-propagate add.
- Valid/ready on input and output; sits between the operand staging logic and the result writeback in the multiplier datapath.

---
 rtl/csa_booth16_pkg.sv | 31 +++
 rtl/booth16_pp_gen.sv | 47 ++++
 rtl/csa_booth16_seq_mult.sv | 141 ++++++++++++++
 tb/tb_csa_booth16_seq_mult.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/csa_booth16_pkg.sv
// Shared types and helpers for the radix-16 Booth carry-save multiplier.
package csa_booth16_pkg;

    // Controller state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_PRECOMP = 3'd1;
    localparam state_t ST_ACCUM   = 3'd2;
    localparam state_t ST_RESOLVE = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    // One radix-16 Booth digit, range -8..+8
    typedef logic signed [4:0] booth_digit_t;

    // Digits needed to recode a signed width-bit operand: ceil((width+1)/4)
    function automatic int ndigits(input int width);
        return (width + 4) / 4;
    endfunction

    // Recode a 5-bit window {b[4i+3], b[4i+2], b[4i+1], b[4i], b[4i-1]}
    // into -8*w4 + 4*w3 + 2*w2 + w1 + w0.
    function automatic booth_digit_t booth16_digit(input logic [4:0] window);
        booth_digit_t hi;
        booth_digit_t lo;
        hi = {window[4], window[4:1]};
        lo = {4'b0000, window[0]};
        return hi + lo;
    endfunction

endpackage

// File: rtl/booth16_pp_gen.sv
// Combinational partial-product generator: selects |d|*A from the
// precomputed odd multiples, negates for negative digits and aligns the
// result to digit position idx (shift by 4*idx), truncated to 2*WIDTH bits.
module booth16_pp_gen
    import csa_booth16_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDXW  = 3
) (
    input  logic [2*WIDTH-1:0] a_ext,
    input  logic [2*WIDTH-1:0] a3,
    input  logic [2*WIDTH-1:0] a5,
    input  logic [2*WIDTH-1:0] a7,
    input  logic [4:0]         digit,
    input  logic [IDXW-1:0]    idx,
    output logic [2*WIDTH-1:0] pp
);

    localparam int PW = 2 * WIDTH;

    logic [3:0]    mag;
    logic [PW-1:0] mult;
    logic [PW-1:0] signed_mult;

    // Pick the magnitude multiple, apply the digit sign, then align
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        mag         = digit[4] ? (4'd0 - digit[3:0]) : digit[3:0];
        mult        = '0;
        signed_mult = '0;
        pp          = '0;
        case (mag)
            4'd1:    mult = a_ext;
            4'd2:    mult = a_ext << 1;
            4'd3:    mult = a3;
            4'd4:    mult = a_ext << 2;
            4'd5:    mult = a5;
            4'd6:    mult = a3 << 1;
            4'd7:    mult = a7;
            4'd8:    mult = a_ext << 3;
            default: mult = '0;
        endcase
        signed_mult = digit[4] ? ({PW{1'b0}} - mult) : mult;
        pp          = signed_mult << {idx, 2'b00};
    end

endmodule

// File: rtl/csa_booth16_seq_mult.sv
// Sequential radix-16 Booth multiplier with a carry-save accumulator.
// One Booth digit is retired per cycle into a 3:2 compressor row; a single
// carry-propagate add resolves the product. Valid/ready on both sides.
// Optional feature macro: CSA_BOOTH16_ACCUMULATE_EN adds acc_in, which
// seeds the sum vector so product_out = A*B + acc_in.
module csa_booth16_seq_mult
    import csa_booth16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
`ifdef CSA_BOOTH16_ACCUMULATE_EN
    input  logic [2*WIDTH-1:0]   acc_in,
`endif
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 busy_out
);

    localparam int NDIGITS = ndigits(WIDTH);
    localparam int BW      = 4 * NDIGITS;
    localparam int PW      = 2 * WIDTH;
    localparam int IDXW    = $clog2(NDIGITS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    state_t          state;
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   a3;
    logic [PW-1:0]   a5;
    logic [PW-1:0]   a7;
    logic [BW:0]     b_sh;      // sign-extended B with the implicit 0 at bit 0
    logic [PW-1:0]   sum;
    logic [PW-1:0]   carry;
    logic [IDXW-1:0] idx;
    logic [PW-1:0]   product;

    logic [PW-1:0]   sum_init;
    logic [PW-1:0]   carry_sh;
    logic [PW-1:0]   pp;
    booth_digit_t    digit;
    logic            accept;

`ifdef CSA_BOOTH16_ACCUMULATE_EN
    assign sum_init = acc_in;
`else
    assign sum_init = '0;
`endif

    assign accept      = (state == ST_IDLE) && valid_in;
    assign ready_out   = (state == ST_IDLE);
    assign busy_out    = (state != ST_IDLE);
    assign valid_out   = (state == ST_DONE);
    assign product_out = product;

    // Current Booth digit comes from the low window of the shifting multiplier
    always_comb begin
        digit    = booth16_digit(b_sh[4:0]);
        carry_sh = {carry[PW-2:0], 1'b0};
    end

    booth16_pp_gen #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_pp_gen (
        .a_ext (a_ext),
        .a3    (a3),
        .a5    (a5),
        .a7    (a7),
        .digit (digit),
        .idx   (idx),
        .pp    (pp)
    );

    // Operand and multiple registers; loaded before every use
    always_ff @(posedge clk_in) begin
        // NOTE: these datapath registers carry no reset because each is written before it is read in any transaction.
        if (accept) begin
            a_ext <= {{WIDTH{multiplicand_in[WIDTH-1]}}, multiplicand_in};
            b_sh  <= {{(BW-WIDTH){multiplier_in[WIDTH-1]}}, multiplier_in, 1'b0};
        end else if (state == ST_ACCUM) begin
            b_sh  <= {{4{b_sh[BW]}}, b_sh[BW:4]};
        end
        if (state == ST_PRECOMP) begin
            a3 <= a_ext + (a_ext << 1);
            a5 <= a_ext + (a_ext << 2);
            a7 <= (a_ext << 3) - a_ext;
        end
    end

    // Controller, carry-save accumulator and final carry-propagate add
    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            state   <= ST_IDLE;
            sum     <= '0;
            carry   <= '0;
            idx     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_in) begin
                        sum   <= sum_init;
                        carry <= '0;
                        idx   <= '0;
                        state <= ST_PRECOMP;
                    end
                end
                ST_PRECOMP: begin
                    idx   <= '0;
                    state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    sum   <= sum ^ carry_sh ^ pp;
                    carry <= (sum & carry_sh) | (sum & pp) | (carry_sh & pp);
                    idx   <= idx + IDXW'(1);
                    if (idx == LAST_IDX) begin
                        state <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    product <= sum + carry_sh;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (ready_in) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_booth16_seq_mult.sv
// Self-checking bench for csa_booth16_seq_mult (WIDTH=16).
// Directed steps with a scoreboard queue of expected products.
module tb_csa_booth16_seq_mult;

    localparam int WIDTH = 16;
    localparam int PW    = 2 * WIDTH;

    logic             clk_in;
    logic             rst_in;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] multiplicand_in;
    logic [WIDTH-1:0] multiplier_in;
    logic             valid_out;
    logic             ready_in;
    logic [PW-1:0]    product_out;
    logic             busy_out;
`ifdef CSA_BOOTH16_ACCUMULATE_EN
    logic [PW-1:0]    acc_in;
`endif

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] sb_q[$];

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    csa_booth16_seq_mult #(.WIDTH(WIDTH)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
`ifdef CSA_BOOTH16_ACCUMULATE_EN
        .acc_in          (acc_in),
`endif
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .product_out     (product_out),
        .busy_out        (busy_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return PW'(p);
    endfunction

    // Present operands, wait for acceptance, optionally record the expected result
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [PW-1:0] exp, input bit push, input bit hold);
        int w;
        multiplicand_in = a;
        multiplier_in   = b;
        valid_in        = 1'b1;
        w = 0;
        while (!ready_out && w < 50) begin
            tick();
            w++;
        end
        if (w == 50) check("send_ready_timeout", ready_out, 1'b1);
        if (push) sb_q.push_back(exp);
        tick();
        if (!hold) valid_in = 1'b0;
    endtask

    // Wait for valid_out within a bound and compare against the scoreboard
    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!valid_out && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_valid"}, valid_out, 1'b1);
        if (sb_q.size() > 0) check(tag, product_out, sb_q.pop_front());
        else check({tag, "_sb_empty"}, sb_q.size(), 1);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [PW-1:0]    exp_bp;

        rst_in          = 1'b1;
        valid_in        = 1'b0;
        ready_in        = 1'b1;
        multiplicand_in = '0;
        multiplier_in   = '0;
`ifdef CSA_BOOTH16_ACCUMULATE_EN
        acc_in          = '0;
`endif
        tick();
        tick();
        check("rst_ready", ready_out, 1'b1);
        check("rst_valid", valid_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_product", product_out, 32'h0);
        rst_in = 1'b0;
        tick();

        // Basic product and latency
        send(16'd3, 16'd5, 32'h0000000F, 1'b1, 1'b0);
        wait_result("p3x5", 7);
        tick();

        // Corner operands
        send(16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b0);
        wait_result("min_x_min", 7);
        tick();
        send(16'hFFFF, 16'h0001, 32'hFFFFFFFF, 1'b1, 1'b0);
        wait_result("m1_x_1", 7);
        tick();
        send(16'h7FFF, 16'h8000, 32'hC0008000, 1'b1, 1'b0);
        wait_result("max_x_min", 7);
        tick();

        // Random operands against the behavioural model
        for (int i = 0; i < 4; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            send(ra, rb, model(ra, rb), 1'b1, 1'b0);
            wait_result("rand", 7);
            tick();
        end

        // Backpressure: result held, new operands ignored
        ready_in = 1'b0;
        exp_bp   = model(16'hFB2E, 16'h0237);
        send(16'hFB2E, 16'h0237, exp_bp, 1'b1, 1'b0);
        wait_result("bp", 7);
        for (int i = 0; i < 10; i++) begin
            valid_in        = (i % 2 == 0);
            multiplicand_in = WIDTH'(16'h1111 * i);
            multiplier_in   = WIDTH'(16'h0101 * i + 1);
            tick();
            check("bp_valid_hold", valid_out, 1'b1);
            check("bp_product_hold", product_out, exp_bp);
            check("bp_ready_low", ready_out, 1'b0);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        tick();
        check("bp_release_valid", valid_out, 1'b0);
        check("bp_release_ready", ready_out, 1'b1);
        tick();
        check("bp_not_accepted", busy_out, 1'b0);

        // Reset during the third accumulate cycle
        send(16'd5, 16'd7, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("mid_busy", busy_out, 1'b1);
        rst_in = 1'b1;
        tick();
        check("mid_rst_valid", valid_out, 1'b0);
        check("mid_rst_busy", busy_out, 1'b0);
        check("mid_rst_ready", ready_out, 1'b1);
        check("mid_rst_product", product_out, 32'h0);
        rst_in = 1'b0;
        send(16'd7, 16'd9, 32'd63, 1'b1, 1'b0);
        wait_result("after_rst", 7);
        tick();

        // Back-to-back with valid_in held high
        send(16'd123, 16'hFF85, model(16'd123, 16'hFF85), 1'b1, 1'b1);
        multiplicand_in = 16'h4321;
        multiplier_in   = 16'h00FE;
        sb_q.push_back(model(16'h4321, 16'h00FE));
        wait_result("b2b_first", 7);
        tick();
        check("b2b_idle_ready", ready_out, 1'b1);
        check("b2b_idle_valid", valid_out, 1'b0);
        tick();
        check("b2b_accept_busy", busy_out, 1'b1);
        check("b2b_accept_ready", ready_out, 1'b0);
        valid_in = 1'b0;
        wait_result("b2b_second", 7);
        tick();

`ifdef CSA_BOOTH16_ACCUMULATE_EN
        // Multiply-accumulate
        acc_in = 32'hFFFFFFFA;
        send(16'd2, 16'd3, 32'h00000000, 1'b1, 1'b0);
        acc_in = '0;
        wait_result("mac_wrap", 7);
        tick();
        acc_in = 32'd100;
        send(16'd2, 16'd3, 32'd106, 1'b1, 1'b0);
        acc_in = '0;
        wait_result("mac_100", 7);
        tick();
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
